// File: rtl/camera_link_if.sv
// Camera Link 10-tap bus: frame/line valid plus ports A-J.
// The source drives it through master, the consumer reads it through slave.
interface camera_link_if;
    logic       cl_fval;
    logic       cl_z_lval;
    logic [7:0] cl_port_a, cl_port_b, cl_port_c, cl_port_d, cl_port_e;
    logic [7:0] cl_port_f, cl_port_g, cl_port_h, cl_port_i, cl_port_j;

    modport master (
        output cl_fval, cl_z_lval,
        output cl_port_a, cl_port_b, cl_port_c, cl_port_d, cl_port_e,
        output cl_port_f, cl_port_g, cl_port_h, cl_port_i, cl_port_j
    );
    modport slave (
        input cl_fval, cl_z_lval,
        input cl_port_a, cl_port_b, cl_port_c, cl_port_d, cl_port_e,
        input cl_port_f, cl_port_g, cl_port_h, cl_port_i, cl_port_j
    );
endinterface

// File: rtl/camera_link_sim.sv
// Synthetic dual-half sCMOS source on a 10-tap Camera Link bus.
// Emits a deterministic 12-bit ramp, ten pixels per half packed into three 40-bit words.
module camera_link_sim #(
    parameter int N_COL   = 2560,
    parameter int N_ROW   = 1080,
    parameter int H_BLANK = 32,
    parameter int V_BLANK = 256
) (
    input  logic          clk_85,
    input  logic          reset,
    camera_link_if.master cl
);
    localparam int LINE_CLKS = 3 * N_COL / 10;
    localparam int CNT_MAX   = (V_BLANK > LINE_CLKS) ? ((V_BLANK > H_BLANK) ? V_BLANK : H_BLANK)
                                                     : ((LINE_CLKS > H_BLANK) ? LINE_CLKS : H_BLANK);
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    localparam logic [1:0] VGAP = 2'd0;
    localparam logic [1:0] HGAP = 2'd1;
    localparam logic [1:0] LINE = 2'd2;
    localparam logic [1:0] TAIL = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       phase_q, phase_d;
    logic [11:0]      col_base_q, col_base_d;
    logic [10:0]      row_q, row_d;
    logic [15:0]      frame_q, frame_d;
    logic             fval_q, fval_d;
    logic             lval_q, lval_d;
    logic [39:0]      top_q, top_d;
    logic [39:0]      bot_q, bot_d;

    logic [11:0]      pix_base;
    logic [11:0]      pix;
    logic [119:0]     top_vec, bot_vec;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 1'b1;
        phase_d    = phase_q;
        col_base_d = col_base_q;
        row_d      = row_q;
        frame_d    = frame_q;
        unique case (state_q)
            VGAP: if (cnt_q == CNT_W'(V_BLANK - 1)) begin
                state_d = HGAP;
                cnt_d   = '0;
            end
            HGAP: if (cnt_q == CNT_W'(H_BLANK - 1)) begin
                state_d    = LINE;
                cnt_d      = '0;
                phase_d    = 2'd0;
                col_base_d = '0;
            end
            LINE: begin
                if (cnt_q == CNT_W'(LINE_CLKS - 1)) begin
                    cnt_d = '0;
                    if (row_q < 11'(N_ROW - 1)) begin
                        row_d   = row_q + 1'b1;
                        state_d = HGAP;
                    end else begin
                        state_d = TAIL;
                    end
                end else if (phase_q == 2'd2) begin
                    phase_d    = 2'd0;
                    col_base_d = col_base_q + 12'd10;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            default: if (cnt_q == CNT_W'(H_BLANK - 1)) begin
                state_d = VGAP;
                cnt_d   = '0;
                row_d   = '0;
                frame_d = frame_q + 1'b1;
            end
        endcase
    end

    // Outputs are built from next-state values so the registered bus lines up with LVAL.
    always_comb begin
        pix_base = col_base_d + {1'b0, row_d} + frame_d[11:0];
        top_vec  = '0;
        bot_vec  = '0;
        pix      = '0;
        for (int i = 0; i < 10; i++) begin
            pix = pix_base + 12'(i);
            top_vec[119 - 12*i -: 12] = pix;
            bot_vec[119 - 12*i -: 12] = pix + 12'h800;
        end
        fval_d = (state_d != VGAP);
        lval_d = (state_d == LINE);
        top_d  = '0;
        bot_d  = '0;
        if (lval_d) begin
            unique case (phase_d)
                2'd0:    begin top_d = top_vec[119:80]; bot_d = bot_vec[119:80]; end
                2'd1:    begin top_d = top_vec[79:40];  bot_d = bot_vec[79:40];  end
                default: begin top_d = top_vec[39:0];   bot_d = bot_vec[39:0];   end
            endcase
        end
    end

    always_ff @(posedge clk_85 or posedge reset) begin
        if (reset) begin
            state_q    <= VGAP;
            cnt_q      <= '0;
            phase_q    <= '0;
            col_base_q <= '0;
            row_q      <= '0;
            frame_q    <= '0;
            fval_q     <= 1'b0;
            lval_q     <= 1'b0;
            top_q      <= '0;
            bot_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            phase_q    <= phase_d;
            col_base_q <= col_base_d;
            row_q      <= row_d;
            frame_q    <= frame_d;
            fval_q     <= fval_d;
            lval_q     <= lval_d;
            top_q      <= top_d;
            bot_q      <= bot_d;
        end
    end

    assign cl.cl_fval   = fval_q;
    assign cl.cl_z_lval = lval_q;
    assign {cl.cl_port_a, cl.cl_port_b, cl.cl_port_c, cl.cl_port_d, cl.cl_port_e} = top_q;
    assign {cl.cl_port_f, cl.cl_port_g, cl.cl_port_h, cl.cl_port_i, cl.cl_port_j} = bot_q;
endmodule

// File: tb/tb_camera_link_sim.sv
// Bench for camera_link_sim: default and small configurations against a
// frame-position model of the Camera Link output stream.
module tb_camera_link_sim;
    logic clk_85 = 1'b0;
    logic reset_l, reset_s;
    always #5 clk_85 = ~clk_85;

    camera_link_if cl_l ();
    camera_link_if cl_s ();

    camera_link_sim u_dut_l (.clk_85(clk_85), .reset(reset_l), .cl(cl_l));
    camera_link_sim #(.N_COL(20), .N_ROW(3), .H_BLANK(2), .V_BLANK(4))
        u_dut_s (.clk_85(clk_85), .reset(reset_s), .cl(cl_s));

    logic [81:0] obs_l, obs_s;
    assign obs_l = {cl_l.cl_fval, cl_l.cl_z_lval, cl_l.cl_port_a, cl_l.cl_port_b, cl_l.cl_port_c,
                    cl_l.cl_port_d, cl_l.cl_port_e, cl_l.cl_port_f, cl_l.cl_port_g, cl_l.cl_port_h,
                    cl_l.cl_port_i, cl_l.cl_port_j};
    assign obs_s = {cl_s.cl_fval, cl_s.cl_z_lval, cl_s.cl_port_a, cl_s.cl_port_b, cl_s.cl_port_c,
                    cl_s.cl_port_d, cl_s.cl_port_e, cl_s.cl_port_f, cl_s.cl_port_g, cl_s.cl_port_h,
                    cl_s.cl_port_i, cl_s.cl_port_j};

    int total = 0;
    int bad   = 0;
    int n_s   = 0;

    // Expected bus n clocks after reset release, derived from the frame timeline.
    function automatic logic [81:0] model(input int n, input int ncol, input int nrow,
                                          input int hb, input int vb);
        int lc, per, f, p, q, r, s, k, g, ph;
        logic [119:0] tv, bv;
        lc  = 3 * ncol / 10;
        per = vb + nrow * (hb + lc) + hb;
        f   = n / per;
        p   = n % per;
        if (p < vb) return '0;
        q = p - vb;
        if (q >= nrow * (hb + lc)) return {1'b1, 81'b0};
        r = q / (hb + lc);
        s = q % (hb + lc);
        if (s < hb) return {1'b1, 81'b0};
        k  = s - hb;
        g  = k / 3;
        ph = k % 3;
        tv = '0;
        bv = '0;
        for (int i = 0; i < 10; i++) begin
            tv = {tv[107:0], 12'((g * 10 + i + r + f) % 4096)};
            bv = {bv[107:0], 12'((g * 10 + i + r + f + 2048) % 4096)};
        end
        return {2'b11, tv[119 - 40*ph -: 40], bv[119 - 40*ph -: 40]};
    endfunction

    task automatic chk(input string tag, input logic [81:0] obs, input logic [81:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic run_small(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk_85);
            #1;
            n_s++;
            chk("small_stream", obs_s, model(n_s, 20, 3, 2, 4));
        end
    endtask

    // Assert reset between edges, expect an immediate all-zero bus, then release.
    task automatic pulse_reset_small(input int hold);
        @(posedge clk_85);
        #3 reset_s = 1'b1;
        #1 chk("small_async_reset", obs_s, '0);
        repeat (hold) @(posedge clk_85);
        @(negedge clk_85);
        reset_s = 1'b0;
        n_s     = 0;
    endtask

    logic [39:0] w_t [3];
    logic [39:0] w_b [3];
    logic [11:0] up_t [10];
    logic [11:0] up_b [10];

    initial begin
        reset_l = 1'b1;
        reset_s = 1'b1;
        repeat (3) @(posedge clk_85);
        #1;
        chk("reset_default", obs_l, '0);
        chk("reset_small", obs_s, '0);

        // Default geometry: blanking, first line and receiver-side unpacking.
        @(negedge clk_85);
        reset_l = 1'b0;
        for (int n = 1; n <= 1100; n++) begin
            @(posedge clk_85);
            #1;
            chk("default_stream", obs_l, model(n, 2560, 1080, 32, 256));
            if (n >= 288 && n <= 290) begin
                w_t[n - 288] = obs_l[79:40];
                w_b[n - 288] = obs_l[39:0];
            end
            if (n == 1088) chk("row1_top_pix0", 82'(obs_l[79:68]), 82'd1);
        end
        up_t[0] = w_t[0][39:28]; up_t[1] = w_t[0][27:16]; up_t[2] = w_t[0][15:4];
        up_t[3] = {w_t[0][3:0], w_t[1][39:32]}; up_t[4] = w_t[1][31:20]; up_t[5] = w_t[1][19:8];
        up_t[6] = {w_t[1][7:0], w_t[2][39:36]}; up_t[7] = w_t[2][35:24];
        up_t[8] = w_t[2][23:12]; up_t[9] = w_t[2][11:0];
        up_b[0] = w_b[0][39:28]; up_b[1] = w_b[0][27:16]; up_b[2] = w_b[0][15:4];
        up_b[3] = {w_b[0][3:0], w_b[1][39:32]}; up_b[4] = w_b[1][31:20]; up_b[5] = w_b[1][19:8];
        up_b[6] = {w_b[1][7:0], w_b[2][39:36]}; up_b[7] = w_b[2][35:24];
        up_b[8] = w_b[2][23:12]; up_b[9] = w_b[2][11:0];
        for (int i = 0; i < 10; i++) begin
            chk("unpack_top", 82'(up_t[i]), 82'(i));
            chk("unpack_bot", 82'(up_b[i]), 82'(12'h800 + i));
        end
        reset_l = 1'b1;

        // Small geometry: several frames, then reset during frame 1 row 2.
        @(negedge clk_85);
        reset_s = 1'b0;
        n_s     = 0;
        run_small(53);
        pulse_reset_small(2);
        run_small(65);

        // Random reset points and hold times.
        for (int e = 0; e < 10; e++) begin
            run_small(int'($urandom_range(1, 150)));
            pulse_reset_small(int'($urandom_range(0, 3)));
        end
        run_small(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
